// File: rtl/id_sched_if.sv
// id_sched_if: requester handshakes, recognizer link and result bus of id_sched.
// slave is the scheduler side, master is the requester/recognizer environment side.
interface id_sched_if;
  logic       req0_valid;
  logic [7:0] req0_char;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_char;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] id_char;
  logic       id_out;
  logic       res_valid;
  logic       res_src;
  logic       res_match;
  logic [7:0] res_len;
  logic       res_ovf;
  logic       busy;

  modport slave (
    input  req0_valid, req0_char, req0_last,
    input  req1_valid, req1_char, req1_last,
    input  id_out,
    output req0_ready, req1_ready, id_char,
    output res_valid, res_src, res_match, res_len, res_ovf, busy
  );

  modport master (
    output req0_valid, req0_char, req0_last,
    output req1_valid, req1_char, req1_last,
    output id_out,
    input  req0_ready, req1_ready, id_char,
    input  res_valid, res_src, res_match, res_len, res_ovf, busy
  );
endinterface

// File: rtl/id_sched.sv
// id_sched: arbitrates two char-stream requesters, buffers one token and replays it
// into the shared identifier recognizer. Define ID_SCHED_RR_EN for round-robin arbitration.
module id_sched #(
  parameter logic [7:0]  FLUSH_CHAR = 8'h20,
  parameter int unsigned MAX_LEN    = 16
) (
  input logic       clk,
  input logic       reset,
  id_sched_if.slave bus
);
  localparam int unsigned IW        = $clog2(MAX_LEN);
  localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, REPLAY, SAMPLE} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    tok_buf [MAX_LEN];
  logic [8:0]    len;
  logic [IW-1:0] idx;
  logic          grant;
  logic          ovf;
  logic          pick;
  logic          any_valid;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_char;
  logic          hs;
  logic          room;
  logic [7:0]    id_char_c;
  logic          req0_ready_c;
  logic          req1_ready_c;
  logic          res_valid_q;
  logic          res_src_q;
  logic          res_match_q;
  logic [7:0]    res_len_q;
  logic          res_ovf_q;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign sel_valid = grant ? bus.req1_valid : bus.req0_valid;
  assign sel_last  = grant ? bus.req1_last  : bus.req0_last;
  assign sel_char  = grant ? bus.req1_char  : bus.req0_char;
  assign room      = len < MAX_LEN_W;

`ifdef ID_SCHED_RR_EN
  // Pointer set means req1 is favoured on the next contested grant.
  logic rr_ptr;

  assign pick = rr_ptr ? bus.req1_valid : ~bus.req0_valid;

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (state == SAMPLE)
      rr_ptr <= ~grant;
  end
`else
  assign pick = ~bus.req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    id_char_c    = FLUSH_CHAR;
    hs           = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid)
          state_next = COLLECT;
      end
      COLLECT: begin
        req0_ready_c = ~grant;
        req1_ready_c = grant;
        hs           = sel_valid;
        if (sel_valid && sel_last)
          state_next = REPLAY;
      end
      REPLAY: begin
        id_char_c = tok_buf[idx];
        if ({{(9-IW){1'b0}}, idx} == len - 9'd1)
          state_next = SAMPLE;
      end
      SAMPLE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chars beyond the buffer depth are accepted but dropped; ovf remembers it.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= 1'b0;
      len         <= 9'd0;
      ovf         <= 1'b0;
      idx         <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_len_q   <= 8'd0;
      res_ovf_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= pick;
            len   <= 9'd0;
            ovf   <= 1'b0;
          end
        end
        COLLECT: begin
          if (hs) begin
            if (room)
              len <= len + 9'd1;
            else
              ovf <= 1'b1;
            if (sel_last)
              idx <= '0;
          end
        end
        REPLAY: idx <= idx + IW'(1);
        SAMPLE: begin
          res_valid_q <= 1'b1;
          res_src_q   <= grant;
          res_match_q <= bus.id_out;
          res_len_q   <= len[7:0];
          res_ovf_q   <= ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == COLLECT && hs && room)
      tok_buf[len[IW-1:0]] <= sel_char;
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.id_char    = id_char_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_src    = res_src_q;
  assign bus.res_match  = res_match_q;
  assign bus.res_len    = res_len_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.busy       = (state != IDLE);
endmodule
